// File: rtl/mini_frame_mult_pkg.sv
// Shared types and constants for the Mini_Frame sequential multiplier.
// Holds the FSM state type and the default operand/product widths.
package mini_frame_mult_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int PROD_W    = 2 * WIDTH_DEF;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mini_frame_cond_adder.sv
// Conditional adder for the accumulate step: sum = en ? a + b : a.
// Purely combinational; the caller guarantees no carry-out is needed.
module mini_frame_cond_adder
   import mini_frame_mult_pkg::*;
#(
   parameter int W = PROD_W
) (
   input  logic         i_en,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum
);

   // Add the shifted multiplicand only when the current multiplier bit is set
   always_comb begin
      o_sum = i_a;
      if (i_en) begin
         o_sum = i_a + i_b;
      end
   end

endmodule

// File: rtl/mini_frame_seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one partial product per clock.
// Fixed WIDTH-cycle run, then F is updated together with a one-cycle done pulse.
module mini_frame_seq_multiplier
   import mini_frame_mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk1,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] F,
   output logic               busy,
   output logic               done
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t          r_state;
   logic [PW-1:0]   r_acc;
   logic [PW-1:0]   r_mcand;
   logic [WIDTH-1:0] r_mplr;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_f;
   logic            r_busy;
   logic            r_done;

   state_t          w_state_nxt;
   logic [PW-1:0]   w_acc_nxt;
   logic [PW-1:0]   w_mcand_nxt;
   logic [WIDTH-1:0] w_mplr_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [PW-1:0]   w_f_nxt;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic [PW-1:0]   w_sum;

   mini_frame_cond_adder #(
      .W (PW)
   ) u_add (
      .i_en  (r_mplr[0]),
      .i_a   (r_acc),
      .i_b   (r_mcand),
      .o_sum (w_sum)
   );

   // Next-state and datapath update; the final add result goes straight to F
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_mcand_nxt = r_mcand;
      w_mplr_nxt  = r_mplr;
      w_count_nxt = r_count;
      w_f_nxt     = r_f;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      unique case (r_state)
         IDLE: begin
            w_done_nxt = 1'b0;
            if (start) begin
               w_mcand_nxt = {{WIDTH{1'b0}}, A};
               w_mplr_nxt  = B;
               w_acc_nxt   = '0;
               w_count_nxt = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_acc_nxt   = w_sum;
            w_mcand_nxt = r_mcand << 1;
            w_mplr_nxt  = r_mplr >> 1;
            w_count_nxt = r_count + CW'(1);
            if (r_count == LAST) begin
               w_f_nxt     = w_sum;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any run with no done pulse
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_count <= '0;
         r_f     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_mcand <= w_mcand_nxt;
         r_mplr  <= w_mplr_nxt;
         r_count <= w_count_nxt;
         r_f     <= w_f_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign F    = r_f;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_mini_frame_seq_multiplier.sv
// Bench for mini_frame_seq_multiplier: transaction-level model compared every
// cycle, plus directed literal checks and a randomized traffic phase.
module tb_mini_frame_seq_multiplier;

   logic        clk1;
   logic        rst_n;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] F;
   logic        busy;
   logic        done;

   int n_total;
   int n_pass;

   mini_frame_seq_multiplier #(
      .WIDTH (8)
   ) dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .F     (F),
      .busy  (busy),
      .done  (done)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: an accepted request yields A*B exactly 8 edges later
   logic [15:0] m_f;
   logic [15:0] m_prod;
   logic        m_busy;
   logic        m_done;
   int          m_left;

   always @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         m_f = 0; m_busy = 0; m_done = 0; m_left = 0; m_prod = 0;
      end else if (!m_busy) begin
         m_done = 0;
         if (start) begin
            m_prod = 16'(A * B);
            m_busy = 1;
            m_left = 8;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_f = m_prod;
            m_done = 1;
            m_busy = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the rising edge
   always @(negedge clk1) begin
      check("F", int'(F), int'(m_f));
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
   end

   task automatic go(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk1);
      A = a; B = b; start = 1'b1;
      @(negedge clk1);
      start = 1'b0;
   endtask

   // Wait (bounded) for done at a falling edge; report cycles waited
   task automatic wait_done(input string name, input int exp, output int cyc);
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk1);
         if (done) begin
            cyc = i;
            check(name, int'(F), exp);
            return;
         end
      end
      check({name, "_timeout"}, 0, 1);
   endtask

   int cyc;

   initial begin
      n_total = 0; n_pass = 0;
      rst_n = 1'b0; start = 1'b1; A = 8'd5; B = 8'd7;
      // 1: reset held with start high
      repeat (3) @(negedge clk1);
      check("rst_F", int'(F), 0);
      check("rst_busy", int'(busy), 0);
      #2 rst_n = 1'b1;
      start = 1'b0;

      // 2: 1*1 then 2*1
      go(8'd1, 8'd1);
      wait_done("f_1x1", 1, cyc);
      check("lat_1x1", cyc, 8);
      @(negedge clk1);
      check("done_drop", int'(done), 0);
      go(8'd2, 8'd1);
      wait_done("f_2x1", 2, cyc);

      // 3: max and zero operands
      go(8'd255, 8'd255);
      wait_done("f_max", 16'hFE01, cyc);
      go(8'd0, 8'd200);
      wait_done("f_zero", 0, cyc);
      check("lat_zero", cyc, 8);

      // 4: start held, operands change mid-run, restart in done cycle
      @(negedge clk1);
      A = 8'd7; B = 8'd9; start = 1'b1;
      @(negedge clk1);
      A = 8'd3; B = 8'd3;
      wait_done("f_7x9", 63, cyc);
      wait_done("f_3x3", 9, cyc);
      check("b2b_gap", cyc, 9);
      start = 1'b0;

      // 5: reset mid-run
      go(8'd13, 8'd11);
      repeat (3) @(negedge clk1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_F", int'(F), 0);
      @(negedge clk1);
      #2 rst_n = 1'b1;
      go(8'd5, 8'd6);
      wait_done("f_5x6", 30, cyc);

      // 6: back-to-back sweep 2..19
      @(negedge clk1);
      A = 8'd2; B = 8'd2; start = 1'b1;
      for (int a = 2; a <= 19; a++) begin
         for (int b = 2; b <= 19; b++) begin
            if (!(a == 2 && b == 2)) begin
               A = 8'(a); B = 8'(b);
            end
            if (a == 2 && b == 2) begin
               wait_done("sweep", 4, cyc);
            end else begin
               wait_done("sweep", a * b, cyc);
            end
         end
      end
      start = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         @(negedge clk1);
         start = 1'($urandom_range(0, 1));
         A = 8'($urandom);
         B = 8'($urandom);
      end
      start = 1'b0;
      repeat (12) @(negedge clk1);

      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
